// File: rtl/filter_cfg_ctrl_if.sv
// Bus bundle between the IIR filter configuration controller and its surroundings:
// coefficient config port, sample stream and the filter datapath hookup.
interface filter_cfg_ctrl_if #(
  parameter int WIDTH = 31
);
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [WIDTH:0]   cfg_wdata;
  logic [WIDTH:0]   cfg_rdata;
  logic             cfg_commit;
  logic             bypass;
  logic [WIDTH:0]   x_in;
  logic             x_valid;
  logic [WIDTH:0]   filt_x;
  logic [WIDTH:0]   filt_a1;
  logic [WIDTH:0]   filt_b0;
  logic [WIDTH:0]   filt_b1;
  logic             filt_rst;
  logic [WIDTH:0]   filt_y;
  logic [WIDTH:0]   y_out;
  logic             y_valid;
  logic             busy;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_commit, bypass, x_in, x_valid, filt_y,
    output cfg_rdata, filt_x, filt_a1, filt_b0, filt_b1, filt_rst, y_out, y_valid, busy
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_commit, bypass, x_in, x_valid, filt_y,
    input  cfg_rdata, filt_x, filt_a1, filt_b0, filt_b1, filt_rst, y_out, y_valid, busy
  );
endinterface

// File: rtl/filter_cfg_ctrl.sv
// Configuration/sequencing controller for a first-order IIR filter: shadow/active
// coefficients, atomic commit with filter flush, settle masking and output register.
module filter_cfg_ctrl #(
  parameter int WIDTH         = 31,
  parameter int FLUSH_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  filter_cfg_ctrl_if.slave   io_cfg
);

  localparam int MAXC  = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH:0]   COEF_ONE    = {{WIDTH{1'b0}}, 1'b1} << (WIDTH / 2);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_filt_rst;
  logic [WIDTH:0]   r_a1_sh, r_b0_sh, r_b1_sh;
  logic [WIDTH:0]   r_a1, r_b0, r_b1;
  logic [WIDTH:0]   r_rdata;
  logic [WIDTH:0]   r_y_out;
  logic             r_y_valid;

  logic [WIDTH:0]   w_a1_sh, w_b0_sh, w_b1_sh;
  logic [WIDTH:0]   w_rdata;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pending_nxt;
  logic             w_load_active;

  // Shadow values including this cycle's write, so a same-cycle commit sees the new word
  always_comb begin
    w_a1_sh = r_a1_sh;
    w_b0_sh = r_b0_sh;
    w_b1_sh = r_b1_sh;
    if (io_cfg.cfg_we) begin
      case (io_cfg.cfg_addr)
        2'd0:    w_a1_sh = io_cfg.cfg_wdata;
        2'd1:    w_b0_sh = io_cfg.cfg_wdata;
        2'd2:    w_b1_sh = io_cfg.cfg_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (io_cfg.cfg_addr)
      2'd0:    w_rdata = r_a1_sh;
      2'd1:    w_rdata = r_b0_sh;
      2'd2:    w_rdata = r_b1_sh;
      default: w_rdata = '0;
    endcase
  end

  // A commit arriving on the last SETTLE cycle is treated like a pending one
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_load_active = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (io_cfg.cfg_commit || r_pending) begin
          w_load_active = 1'b1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = ST_FLUSH;
          w_cnt_nxt     = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (io_cfg.cfg_commit) w_pending_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          if (r_pending || io_cfg.cfg_commit) begin
            w_load_active = 1'b1;
            w_pending_nxt = 1'b0;
            w_state_nxt   = ST_FLUSH;
            w_cnt_nxt     = FLUSH_LOAD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          if (io_cfg.cfg_commit) w_pending_nxt = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = FLUSH_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_FLUSH;
      r_cnt      <= FLUSH_LOAD;
      r_pending  <= 1'b0;
      r_filt_rst <= 1'b1;
      r_a1_sh    <= '0;
      r_b0_sh    <= COEF_ONE;
      r_b1_sh    <= '0;
      r_a1       <= '0;
      r_b0       <= COEF_ONE;
      r_b1       <= '0;
      r_rdata    <= '0;
      r_y_out    <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_filt_rst <= (w_state_nxt == ST_FLUSH);
      r_a1_sh    <= w_a1_sh;
      r_b0_sh    <= w_b0_sh;
      r_b1_sh    <= w_b1_sh;
      if (w_load_active) begin
        r_a1 <= w_a1_sh;
        r_b0 <= w_b0_sh;
        r_b1 <= w_b1_sh;
      end
      r_rdata    <= w_rdata;
      r_y_out    <= io_cfg.bypass ? io_cfg.x_in : io_cfg.filt_y;
      r_y_valid  <= io_cfg.x_valid &
                    (io_cfg.bypass | ((r_state == ST_RUN) & ~io_cfg.cfg_commit));
    end
  end

  assign io_cfg.filt_x    = (r_state != ST_FLUSH && io_cfg.x_valid) ? io_cfg.x_in : '0;
  assign io_cfg.filt_a1   = r_a1;
  assign io_cfg.filt_b0   = r_b0;
  assign io_cfg.filt_b1   = r_b1;
  assign io_cfg.filt_rst  = r_filt_rst;
  assign io_cfg.cfg_rdata = r_rdata;
  assign io_cfg.y_out     = r_y_out;
  assign io_cfg.y_valid   = r_y_valid;
  assign io_cfg.busy      = (r_state != ST_RUN) | r_pending;

endmodule

// File: tb/tb_filter_cfg_ctrl.sv
// Self-checking bench for filter_cfg_ctrl; the filter is modelled as filt_y = filt_x ^ FMASK
// and the output path is scored through a queue of expected {y_valid, y_out} words.
module tb_filter_cfg_ctrl;

  localparam int W = 31;
  localparam logic [W:0] FMASK = 32'h5A5A_5A5A;
  localparam logic [W:0] B0_DEF = 32'h0000_8000;
  localparam int RUN = 0, FLUSH = 1, SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [W+1:0] sb[$];
  logic [W+1:0] got, expv;

  filter_cfg_ctrl_if #(.WIDTH(W)) bus();

  filter_cfg_ctrl #(.WIDTH(W), .FLUSH_CYCLES(2), .SETTLE_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_cfg  (bus)
  );

  always #5 clk = ~clk;
  assign bus.filt_y = bus.filt_x ^ FMASK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus and queue the output expected after the next edge
  task automatic drive(input logic bp, input logic [W:0] xi, input logic xv, input logic cm,
                       input logic we, input logic [1:0] ad, input logic [W:0] wd, input int st);
    logic [W:0] fx;
    bus.bypass = bp; bus.x_in = xi; bus.x_valid = xv; bus.cfg_commit = cm;
    bus.cfg_we = we; bus.cfg_addr = ad; bus.cfg_wdata = wd;
    fx = (st != FLUSH && xv) ? xi : '0;
    if (bp) sb.push_back({xv, xi});
    else    sb.push_back({xv && st == RUN && !cm, fx ^ FMASK});
  endtask

  task automatic test_startup(input string tag);
    int st;
    logic [W:0] xi;
    logic xv;
    for (int n = 1; n <= 8; n++) begin
      st = (n <= 2) ? FLUSH : (n <= 6) ? SETTLE : RUN;
      xi = $urandom;
      xv = (n >= 7) ? (n == 7) : 1'b1;
      drive(1'b0, xi, xv, 1'b0, 1'b0, 2'd0, '0, st);
      #1;
      vectors++;
      if (bus.filt_x !== ((st != FLUSH && xv) ? xi : '0)) begin
        miscompares++;
        $display("[TB] FAIL %s filt_x n=%0d got %h want %h", tag, n, bus.filt_x,
                 (st != FLUSH && xv) ? xi : '0);
      end
      tick();
      got = {bus.y_valid, bus.y_out}; expv = sb.pop_front(); vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("[TB] FAIL %s y_path n=%0d got %h want %h", tag, n, got, expv);
      end
      vectors++;
      if (bus.filt_rst !== (n < 2)) begin
        miscompares++;
        $display("[TB] FAIL %s filt_rst n=%0d got %b want %b", tag, n, bus.filt_rst, n < 2);
      end
      vectors++;
      if (bus.busy !== (n < 6)) begin
        miscompares++;
        $display("[TB] FAIL %s busy n=%0d got %b want %b", tag, n, bus.busy, n < 6);
      end
    end
  endtask

  task automatic test_reset();
    logic [W:0] gv[6];
    logic [W:0] ev[6];
    string nm[6];
    rst_n = 1'b0;
    bus.bypass = 1'b0; bus.x_in = 32'hCAFE_0001; bus.x_valid = 1'b1; bus.cfg_commit = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd1; bus.cfg_wdata = '0;
    tick(); tick();
    gv = '{bus.cfg_rdata, bus.y_out, bus.filt_a1, bus.filt_b0, bus.filt_b1,
           {29'd0, bus.filt_rst, bus.busy, bus.y_valid}};
    ev = '{32'd0, 32'd0, 32'd0, B0_DEF, 32'd0, 32'd6};
    nm = '{"rst_rdata", "rst_y_out", "rst_a1", "rst_b0", "rst_b1", "rst_flags"};
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (gv[i] !== ev[i]) begin
        miscompares++;
        $display("[TB] FAIL %s got %h want %h", nm[i], gv[i], ev[i]);
      end
    end
    rst_n = 1'b1;
    test_startup("startup");
  endtask

  task automatic test_commit_same_cycle();
    int k;
    drive(1'b0, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0001_0000, RUN);
    tick();
    got = {bus.y_valid, bus.y_out}; expv = sb.pop_front(); vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL commit y_path got %h want %h", got, expv);
    end
    vectors++;
    if (bus.filt_b0 !== 32'h0001_0000) begin
      miscompares++;
      $display("[TB] FAIL commit filt_b0 got %h want %h", bus.filt_b0, 32'h0001_0000);
    end
    vectors++;
    if (bus.filt_rst !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL commit flush_start got rst=%b busy=%b want 1 1", bus.filt_rst, bus.busy);
    end
    bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0; bus.x_valid = 1'b0;
    k = 0;
    while (k < 20 && bus.busy) begin
      tick();
      k++;
    end
    vectors++;
    if (k !== 6) begin
      miscompares++;
      $display("[TB] FAIL commit busy_cycles got %0d want 6", k);
    end
  endtask

  task automatic test_shadow_write();
    logic        we[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  ad[6]  = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2};
    logic [W:0]  wd[6]  = '{32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    logic [W:0]  er[6]  = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0001_0000, 32'h0};
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, $urandom, 1'b1, 1'b0, we[n], ad[n], wd[n], RUN);
      tick();
      got = {bus.y_valid, bus.y_out}; expv = sb.pop_front(); vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("[TB] FAIL shadow y_path n=%0d got %h want %h", n, got, expv);
      end
      vectors++;
      if (bus.cfg_rdata !== er[n]) begin
        miscompares++;
        $display("[TB] FAIL shadow rdata n=%0d got %h want %h", n, bus.cfg_rdata, er[n]);
      end
      vectors++;
      if (bus.filt_a1 !== 32'h0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL shadow active_a1 n=%0d got %h busy=%b want 0 busy=0", n, bus.filt_a1, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st[14] = '{RUN, FLUSH, FLUSH, SETTLE, SETTLE, SETTLE, SETTLE,
                   FLUSH, FLUSH, SETTLE, SETTLE, SETTLE, SETTLE, RUN};
    logic [W:0] eb1;
    for (int n = 0; n < 13; n++) begin
      drive(1'b0, $urandom, 1'($urandom_range(0, 1)), (n == 0 || n == 4 || n == 5),
            (n <= 1), 2'd2, (n == 0) ? 32'h0000_1111 : 32'h0000_2222, st[n]);
      tick();
      got = {bus.y_valid, bus.y_out}; expv = sb.pop_front(); vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("[TB] FAIL b2b y_path n=%0d got %h want %h", n, got, expv);
      end
      vectors++;
      if (bus.busy !== (st[n+1] != RUN) || bus.filt_rst !== (st[n+1] == FLUSH)) begin
        miscompares++;
        $display("[TB] FAIL b2b flags n=%0d got busy=%b rst=%b want busy=%b rst=%b", n,
                 bus.busy, bus.filt_rst, st[n+1] != RUN, st[n+1] == FLUSH);
      end
      eb1 = (n + 1 >= 7) ? 32'h0000_2222 : 32'h0000_1111;
      vectors++;
      if (bus.filt_b1 !== eb1) begin
        miscompares++;
        $display("[TB] FAIL b2b filt_b1 n=%0d got %h want %h", n, bus.filt_b1, eb1);
      end
    end
  endtask

  task automatic test_bypass();
    int st[9] = '{RUN, FLUSH, FLUSH, SETTLE, SETTLE, SETTLE, SETTLE, RUN, RUN};
    logic bp, xv;
    logic [W:0] xi;
    for (int n = 0; n < 8; n++) begin
      bp = (n == 1 || n == 2 || n == 5);
      xv = (n != 2 && n != 6);
      xi = (n == 1) ? 32'h0000_1234 : $urandom;
      drive(bp, xi, xv, (n == 0), 1'b0, 2'd0, '0, st[n]);
      #1;
      vectors++;
      if (bus.filt_x !== ((st[n] != FLUSH && xv) ? xi : '0)) begin
        miscompares++;
        $display("[TB] FAIL bypass filt_x n=%0d got %h want %h", n, bus.filt_x,
                 (st[n] != FLUSH && xv) ? xi : '0);
      end
      tick();
      got = {bus.y_valid, bus.y_out}; expv = sb.pop_front(); vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("[TB] FAIL bypass y_path n=%0d got %h want %h", n, got, expv);
      end
      vectors++;
      if (bus.busy !== (st[n+1] != RUN)) begin
        miscompares++;
        $display("[TB] FAIL bypass busy n=%0d got %b want %b", n, bus.busy, st[n+1] != RUN);
      end
    end
  endtask

  task automatic test_reset_mid();
    int st[5] = '{RUN, FLUSH, FLUSH, SETTLE, SETTLE};
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, $urandom, 1'b1, (n == 0 || n == 4), (n == 1 || n == 4),
            (n == 1) ? 2'd0 : 2'd1, (n == 1) ? 32'h0000_7777 : 32'h0000_3333, st[n]);
      tick();
      got = {bus.y_valid, bus.y_out}; expv = sb.pop_front(); vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("[TB] FAIL rmid y_path n=%0d got %h want %h", n, got, expv);
      end
    end
    vectors++;
    if (bus.busy !== 1'b1 || bus.filt_a1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL rmid pre_reset got busy=%b a1=%h want 1 deadbeef", bus.busy, bus.filt_a1);
    end
    bus.cfg_commit = 1'b0; bus.cfg_we = 1'b0;
    sb.delete();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.filt_rst, bus.busy, bus.y_valid} !== 3'b110 || bus.y_out !== '0 ||
        bus.filt_a1 !== '0 || bus.filt_b0 !== B0_DEF || bus.filt_b1 !== '0) begin
      miscompares++;
      $display("[TB] FAIL rmid async got rst=%b busy=%b yv=%b y=%h a1=%h b0=%h b1=%h want 1 1 0 0 0 %h 0",
               bus.filt_rst, bus.busy, bus.y_valid, bus.y_out, bus.filt_a1, bus.filt_b0,
               bus.filt_b1, B0_DEF);
    end
    tick();
    rst_n = 1'b1;
    test_startup("restart");
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd0, '0, RUN);
    tick();
    void'(sb.pop_front());
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd1, '0, RUN);
    vectors++;
    if (bus.cfg_rdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL rmid shadow_a1 got %h want 0", bus.cfg_rdata);
    end
    tick();
    void'(sb.pop_front());
    vectors++;
    if (bus.cfg_rdata !== B0_DEF) begin
      miscompares++;
      $display("[TB] FAIL rmid shadow_b0 got %h want %h", bus.cfg_rdata, B0_DEF);
    end
  endtask

  initial begin
    test_reset();
    test_commit_same_cycle();
    test_shadow_write();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
